div_sqrt_digit_collector: RTL and testbench

Back end of the div/sqrt iteration datapath. Each cycle it consumes the carry-out and partial remainder of one iteration step and shifts the quotient/root digit into a result register. After a programmed number of digits it computes the sticky bit from the final partial remainder and presents the result to the rounding stage over a valid/ready handshake. It sits between the iteration unit chain and the normalisation/rounding logic of the div_sqrt top.

---
 rtl/div_sqrt_digit_collector_if.sv | 40 ++++
 rtl/div_sqrt_digit_collector.sv | 133 +++++++++++++
 tb/tb_div_sqrt_digit_collector.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sqrt_digit_collector_if.sv
// Handshake/data bundle between the div/sqrt iteration chain, the digit
// collector and the rounding stage. The master side is whoever drives the
// iteration results and consumes the result. The slave side is the collector.
interface div_sqrt_digit_collector_if #(
  parameter int C_MANT = 23
);
  localparam int C_QUOT = C_MANT + 3;
  localparam int C_CNT  = $clog2(C_QUOT + 1);

  // Operation control
  logic              Start_SI;
  logic [C_CNT-1:0]  Iter_num_DI;
  logic              Kill_SI;

  // Per-iteration digit stream
  logic              Digit_valid_SI;
  logic              Carry_DI;
  logic [C_MANT+1:0] Rem_DI;

  // Result towards the rounding stage
  logic              Busy_SO;
  logic              Result_valid_SO;
  logic              Result_ready_SI;
  logic [C_QUOT-1:0] Quot_DO;
  logic              Sticky_SO;

  modport master (
    output Start_SI, Iter_num_DI, Kill_SI,
    output Digit_valid_SI, Carry_DI, Rem_DI,
    output Result_ready_SI,
    input  Busy_SO, Result_valid_SO, Quot_DO, Sticky_SO
  );

  modport slave (
    input  Start_SI, Iter_num_DI, Kill_SI,
    input  Digit_valid_SI, Carry_DI, Rem_DI,
    input  Result_ready_SI,
    output Busy_SO, Result_valid_SO, Quot_DO, Sticky_SO
  );
endinterface

// File: rtl/div_sqrt_digit_collector.sv
// Digit collector for the div/sqrt iteration datapath.
// Shifts one quotient/root digit (the iteration carry-out) per accepted step
// into a right-aligned result register. After the programmed number of digits
// it captures the sticky bit from the last partial remainder and holds the
// result on a valid/ready handshake until the rounding stage takes it.
// Kill aborts from any state and clears the result.
module div_sqrt_digit_collector #(
  parameter int C_MANT = 23
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RI,
  div_sqrt_digit_collector_if.slave     bus
);

  localparam int C_QUOT = C_MANT + 3;
  localparam int C_CNT  = $clog2(C_QUOT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [C_CNT-1:0]  cnt_q,    cnt_d;
  logic [C_QUOT-1:0] quot_q,   quot_d;
  logic              sticky_q, sticky_d;
  logic              busy_q,   busy_d;
  logic              valid_q,  valid_d;

  logic [C_CNT-1:0]  iter_eff;
  logic              last_digit;
  logic              digit_take;
  logic              handshake;

  // Clamp the requested digit count into 1..C_QUOT.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    iter_eff = bus.Iter_num_DI;
    if (bus.Iter_num_DI == '0) begin
      iter_eff = C_CNT'(1);
    end else if (bus.Iter_num_DI > C_CNT'(C_QUOT)) begin
      iter_eff = C_CNT'(C_QUOT);
    end
  end

  // Qualifiers for the per-state events.
  always_comb begin
    digit_take = (state_q == COLLECT) && bus.Digit_valid_SI;
    last_digit = digit_take && (cnt_q == C_CNT'(1));
    handshake  = (state_q == RESULT) && bus.Result_ready_SI;
  end

  // Next-state and datapath update; Kill overrides every other event.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    sticky_d = sticky_q;

    if (bus.Kill_SI) begin
      state_d  = IDLE;
      cnt_d    = '0;
      quot_d   = '0;
      sticky_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Start_SI) begin
            state_d  = COLLECT;
            cnt_d    = iter_eff;
            quot_d   = '0;
            sticky_d = 1'b0;
          end
        end

        COLLECT: begin
          if (digit_take) begin
            quot_d = {quot_q[C_QUOT-2:0], bus.Carry_DI};
            cnt_d  = cnt_q - C_CNT'(1);
            if (last_digit) begin
              // Raw sticky: sign correction of the remainder is left to rounding.
              sticky_d = |bus.Rem_DI;
              state_d  = RESULT;
            end
          end
        end

        RESULT: begin
          if (handshake) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they leave a flop directly.
  always_comb begin
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RESULT);
  end

  // State, counter and result registers with asynchronous reset.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (Rst_RI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quot_q   <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.Busy_SO         = busy_q;
  assign bus.Result_valid_SO = valid_q;
  assign bus.Quot_DO         = quot_q;
  assign bus.Sticky_SO       = sticky_q;

endmodule

// File: tb/tb_div_sqrt_digit_collector.sv
// Scoreboard bench for div_sqrt_digit_collector: the stimulus side computes
// each expected result arithmetically and queues it; a monitor pops and
// compares whenever a result handshake is presented.
module tb_div_sqrt_digit_collector;

  localparam int C_MANT = 23;
  localparam int C_QUOT = C_MANT + 3;

  typedef struct {
    logic [C_QUOT-1:0] quot;
    logic              sticky;
  } exp_t;

  logic clk;
  logic rst;

  div_sqrt_digit_collector_if #(.C_MANT(C_MANT)) bus ();

  div_sqrt_digit_collector #(.C_MANT(C_MANT)) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .bus    (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  int   cyc = 0;
  int   start_cyc = 0;
  int   first_valid_cyc = -1;
  int   valid_cnt = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.Result_valid_SO) begin
      valid_cnt++;
      if (!prev_valid) first_valid_cyc = cyc;
    end
    prev_valid = bus.Result_valid_SO;
    if (!rst && bus.Result_valid_SO && bus.Result_ready_SI && !bus.Kill_SI) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got quot %0h with no result expected", bus.Quot_DO);
      end else begin
        e = exp_q.pop_front();
        check("result_quot", 64'(bus.Quot_DO), 64'(e.quot));
        check("result_sticky", 64'(bus.Sticky_SO), 64'(e.sticky));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.Start_SI       = 1'b0;
    bus.Iter_num_DI    = '0;
    bus.Kill_SI        = 1'b0;
    bus.Digit_valid_SI = 1'b0;
    bus.Carry_DI       = 1'b0;
    bus.Rem_DI         = '0;
  endtask

  // Called at #1 after a rising edge; leaves the bench in cycle 1 of the op.
  task automatic start_op(input int n_req);
    bus.Start_SI    = 1'b1;
    bus.Iter_num_DI = 5'(n_req);
    start_cyc       = cyc;
    valid_cnt       = 0;
    @(posedge clk); #1;
    bus.Start_SI    = 1'b0;
  endtask

  // Presents junk (and a stray Start) for 'gap' cycles, then one valid digit.
  task automatic send_digit(input bit d, input logic [C_MANT+1:0] r, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.Digit_valid_SI = 1'b0;
      bus.Carry_DI       = 1'($urandom);
      bus.Rem_DI         = (C_MANT+2)'($urandom);
      bus.Start_SI       = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.Start_SI       = 1'($urandom);
    bus.Digit_valid_SI = 1'b1;
    bus.Carry_DI       = d;
    bus.Rem_DI         = r;
    @(posedge clk); #1;
    bus.Digit_valid_SI = 1'b0;
    bus.Start_SI       = 1'b0;
  endtask

  // Full operation. With stall > 0 ready is held low for 'stall' RESULT
  // cycles while stray digits and starts are presented.
  task automatic run_op(input int n_req, input bit digs[$], input logic [C_MANT+1:0] last_rem,
                        input int gap_lo, input int gap_hi, input int stall);
    int                n_eff;
    logic [C_QUOT-1:0] q;
    exp_t              e;
    n_eff = (n_req == 0) ? 1 : (n_req > C_QUOT) ? C_QUOT : n_req;
    bus.Result_ready_SI = (stall == 0);
    start_op(n_req);
    q = '0;
    for (int i = 0; i < n_eff; i++) begin
      q = {q[C_QUOT-2:0], digs[i]};
      send_digit(digs[i], (i == n_eff - 1) ? last_rem : (C_MANT+2)'($urandom),
                 int'($urandom_range(gap_hi, gap_lo)));
    end
    e.quot   = q;
    e.sticky = (last_rem != 0);
    exp_q.push_back(e);
    @(negedge clk);
    check("valid_after_last_digit", 64'(bus.Result_valid_SO), 64'd1);
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        bus.Digit_valid_SI = 1'b1;
        bus.Carry_DI       = ~q[0];
        bus.Rem_DI         = (C_MANT+2)'($urandom);
        bus.Start_SI       = 1'b1;
        @(negedge clk);
        check("valid_held_no_ready", 64'(bus.Result_valid_SO), 64'd1);
        check("quot_stable_no_ready", 64'(bus.Quot_DO), 64'(q));
      end
      @(posedge clk); #1;
      bus.Digit_valid_SI  = 1'b0;
      bus.Start_SI        = 1'b1;
      bus.Result_ready_SI = 1'b1;
      @(posedge clk); #1;
      bus.Start_SI        = 1'b0;
      @(negedge clk);
      check("idle_after_handshake", 64'(bus.Busy_SO), 64'd0);
      check("no_valid_after_handshake", 64'(bus.Result_valid_SO), 64'd0);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit                dq[$];
    logic [C_MANT+1:0] r;

    idle_inputs();
    bus.Result_ready_SI = 1'b1;
    rst = 1'b1;
    #12;
    check("reset_busy", 64'(bus.Busy_SO), 64'd0);
    check("reset_valid", 64'(bus.Result_valid_SO), 64'd0);
    check("reset_quot", 64'(bus.Quot_DO), 64'd0);
    check("reset_sticky", 64'(bus.Sticky_SO), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic collect: 1,0,1,1 -> 0xB, valid exactly one cycle at cycle 5.
    dq = {1'b1, 1'b0, 1'b1, 1'b1};
    run_op(4, dq, '0, 0, 0, 0);
    @(negedge clk);
    check("basic_valid_cycles", 64'(valid_cnt), 64'd1);
    check("basic_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd5);
    check("busy_low_after_op", 64'(bus.Busy_SO), 64'd0);

    // Digits in IDLE are ignored: the last result stays put.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.Digit_valid_SI = 1'b1;
      bus.Carry_DI       = 1'b1;
      bus.Rem_DI         = '1;
      @(negedge clk);
      check("idle_digit_ignored_quot", 64'(bus.Quot_DO), 64'hB);
      check("idle_digit_ignored_busy", 64'(bus.Busy_SO), 64'd0);
      @(posedge clk); #1;
    end
    bus.Digit_valid_SI = 1'b0;

    // Full width with sticky.
    dq = {};
    for (int i = 0; i < C_QUOT; i++) dq.push_back(1'b1);
    run_op(26, dq, (C_MANT+2)'(1), 0, 0, 0);
    check("full_width_busy_low", 64'(bus.Busy_SO), 64'd0);

    // Iter_num 0 collects a single digit; above C_QUOT saturates.
    dq = {1'b1};
    run_op(0, dq, '0, 0, 0, 0);
    dq = {};
    for (int i = 0; i < C_QUOT; i++) dq.push_back(1'($urandom));
    run_op(31, dq, (C_MANT+2)'(3), 0, 1, 0);

    // Stalls and backpressure: digits 1,1,0 with gaps, ready low 5 cycles.
    dq = {1'b1, 1'b1, 1'b0};
    run_op(3, dq, (C_MANT+2)'(5), 1, 2, 5);

    // Kill together with Start in IDLE stays IDLE.
    bus.Kill_SI     = 1'b1;
    bus.Start_SI    = 1'b1;
    bus.Iter_num_DI = 5'd3;
    @(posedge clk); #1;
    bus.Kill_SI  = 1'b0;
    bus.Start_SI = 1'b0;
    @(negedge clk);
    check("kill_start_idle_busy", 64'(bus.Busy_SO), 64'd0);
    check("kill_start_idle_quot", 64'(bus.Quot_DO), 64'd0);
    @(posedge clk); #1;

    // Kill after 2 of 4 digits.
    start_op(4);
    send_digit(1'b1, (C_MANT+2)'($urandom), 0);
    send_digit(1'b1, (C_MANT+2)'($urandom), 0);
    bus.Kill_SI        = 1'b1;
    bus.Digit_valid_SI = 1'b1;
    bus.Carry_DI       = 1'b1;
    @(posedge clk); #1;
    bus.Kill_SI        = 1'b0;
    bus.Digit_valid_SI = 1'b0;
    @(negedge clk);
    check("kill_collect_busy", 64'(bus.Busy_SO), 64'd0);
    check("kill_collect_quot", 64'(bus.Quot_DO), 64'd0);
    check("kill_collect_valid", 64'(bus.Result_valid_SO), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Kill in RESULT with ready high: no handshake, outputs cleared.
    bus.Result_ready_SI = 1'b0;
    start_op(2);
    send_digit(1'b1, (C_MANT+2)'(7), 0);
    send_digit(1'b1, (C_MANT+2)'(7), 0);
    @(negedge clk);
    check("kill_result_valid_before", 64'(bus.Result_valid_SO), 64'd1);
    #1;
    bus.Kill_SI         = 1'b1;
    bus.Result_ready_SI = 1'b1;
    @(posedge clk); #1;
    bus.Kill_SI = 1'b0;
    @(negedge clk);
    check("kill_result_busy", 64'(bus.Busy_SO), 64'd0);
    check("kill_result_valid", 64'(bus.Result_valid_SO), 64'd0);
    check("kill_result_quot", 64'(bus.Quot_DO), 64'd0);
    check("kill_result_sticky", 64'(bus.Sticky_SO), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset mid-COLLECT.
    start_op(4);
    send_digit(1'b1, (C_MANT+2)'(1), 0);
    send_digit(1'b1, (C_MANT+2)'(1), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_busy", 64'(bus.Busy_SO), 64'd0);
    check("async_reset_quot", 64'(bus.Quot_DO), 64'd0);
    check("async_reset_valid", 64'(bus.Result_valid_SO), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    dq = {1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_op(5, dq, '0, 0, 0, 0);

    // Randomised operations.
    for (int k = 0; k < 30; k++) begin
      dq = {};
      for (int i = 0; i < C_QUOT; i++) dq.push_back(1'($urandom));
      r = ($urandom_range(3, 0) == 0) ? '0 : (C_MANT+2)'($urandom);
      run_op(int'($urandom_range(31, 0)), dq, r, 0, 2,
             ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(3, 1)));
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
